pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 32 +++
 rtl/pipe_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Purpose: hazard/jump/halt request inputs and hold/flush/redirect outputs of pipe_ctrl.
// Latency: pure wiring, no storage.
// Backpressure: none; hold_flag_o is the stall that pipe registers obey.
interface pipe_ctrl_if;
    logic        bus_hold_i;
    logic        ld_use_i;
    logic        div_busy_i;
    logic        mem_wait_i;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        halt_req_i;
    logic [2:0]  hold_flag_o;
    logic [2:0]  flush_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halt_ack_o;
    logic        mem_err_o;

    modport master (
        output bus_hold_i, ld_use_i, div_busy_i, mem_wait_i,
        output jump_req_i, jump_addr_i, halt_req_i,
        input  hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
        input  halt_ack_o, mem_err_o
    );

    modport slave (
        input  bus_hold_i, ld_use_i, div_busy_i, mem_wait_i,
        input  jump_req_i, jump_addr_i, halt_req_i,
        output hold_flag_o, flush_flag_o, jump_flag_o, jump_addr_o,
        output halt_ack_o, mem_err_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline hold/flush arbiter with debug halt drain; PIPE_CTRL_MEM_TIMEOUT_EN adds mem-wait timeout.
// Latency: hold/flush/jump outputs combinational same cycle; halt_ack_o registered from FSM state.
// Backpressure: stalls are expressed as the max hold code; a suppressed jump is re-presented by EX.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave pc
);
    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_PC    = 3'd1;
    localparam logic [2:0] HOLD_IF    = 3'd2;
    localparam logic [2:0] HOLD_ID    = 3'd3;
    localparam logic [2:0] HOLD_EX    = 3'd4;
    localparam logic [2:0] HOLD_MEM   = 3'd5;
    localparam logic [2:0] FLUSH_NONE = 3'd0;
    localparam logic [2:0] FLUSH_EX   = 3'd4;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t     state_q;
    logic [3:0] drain_cnt_q;
    logic       halt_ack_q;
    logic       mem_req;
    logic       mem_err;
    logic [2:0] hold_code;
    logic       jump_ok;

`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] tmo_cnt_q;
    logic [7:0] tmo_cnt_d;

    // The abort fires in the MEM_TIMEOUT-th consecutive wait cycle, so the count compares against one less.
    always_comb begin
        mem_err = pc.mem_wait_i && (tmo_cnt_q == TMO_LAST);
        mem_req = pc.mem_wait_i && !mem_err;
        if (!pc.mem_wait_i || mem_err) begin
            tmo_cnt_d = 8'd0;
        end else if (tmo_cnt_q == 8'hFF) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    localparam logic [7:0] TMO_CFG = 8'(MEM_TIMEOUT);

    logic unused_mem_timeout;
    assign unused_mem_timeout = ^TMO_CFG;
    assign mem_err = 1'b0;
    assign mem_req = pc.mem_wait_i;
`endif

    // Codes are ordered by stage, so a priority chain yields the numeric maximum.
    always_comb begin
        hold_code = HOLD_NONE;
        if (mem_req) begin
            hold_code = HOLD_MEM;
        end else if (pc.div_busy_i) begin
            hold_code = HOLD_EX;
        end else if (pc.ld_use_i) begin
            hold_code = HOLD_ID;
        end else if (state_q != ST_RUN) begin
            hold_code = HOLD_IF;
        end else if (pc.bus_hold_i) begin
            hold_code = HOLD_PC;
        end
        jump_ok = pc.jump_req_i && (hold_code < HOLD_EX);
    end

    assign pc.hold_flag_o  = rst ? hold_code : HOLD_NONE;
    assign pc.flush_flag_o = (rst && jump_ok) ? FLUSH_EX : FLUSH_NONE;
    assign pc.jump_flag_o  = rst && jump_ok;
    assign pc.jump_addr_o  = (rst && jump_ok) ? pc.jump_addr_i : 32'd0;
    assign pc.halt_ack_o   = halt_ack_q;
    assign pc.mem_err_o    = rst && mem_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 4'd0;
            halt_ack_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pc.halt_req_i) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (!pc.halt_req_i) begin
                        state_q     <= ST_RUN;
                        drain_cnt_q <= 4'd0;
                    end else if (jump_ok) begin
                        // A redirect refills the front end, so draining starts over.
                        drain_cnt_q <= DRAIN_LOAD;
                    end else if (hold_code == HOLD_IF) begin
                        if (drain_cnt_q == 4'd1) begin
                            state_q     <= ST_HALTED;
                            drain_cnt_q <= 4'd0;
                            halt_ack_q  <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 4'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (!pc.halt_req_i) begin
                        state_q    <= ST_RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_RUN;
                    drain_cnt_q <= 4'd0;
                    halt_ack_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: self-checking bench for pipe_ctrl against a queue/arithmetic reference model.
// Latency: outputs sampled 3 time units after each rising edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_pipe_ctrl;
    localparam int MT = 8;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if pc_if();

    pipe_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .pc  (pc_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 running, 1 draining, 2 halted.
    int m_phase;
    int m_left;
    int m_run;
    logic [2:0]  e_hold;
    logic [2:0]  e_flush;
    logic        e_jf;
    logic [31:0] e_ja;
    logic        e_ack;
    logic        e_err;

    function automatic logic [40:0] dut_vec();
        return {pc_if.hold_flag_o, pc_if.flush_flag_o, pc_if.jump_flag_o,
                pc_if.jump_addr_o, pc_if.halt_ack_o, pc_if.mem_err_o};
    endfunction

    function automatic logic [40:0] exp_vec();
        return {e_hold, e_flush, e_jf, e_ja, e_ack, e_err};
    endfunction

    task automatic set_in(input logic bh, input logic lu, input logic db, input logic mw,
                          input logic jr, input logic [31:0] ja, input logic hr);
        pc_if.bus_hold_i  = bh;
        pc_if.ld_use_i    = lu;
        pc_if.div_busy_i  = db;
        pc_if.mem_wait_i  = mw;
        pc_if.jump_req_i  = jr;
        pc_if.jump_addr_i = ja;
        pc_if.halt_req_i  = hr;
    endtask

    task automatic model_clear();
        m_phase = 0;
        m_left  = 0;
        m_run   = 0;
    endtask

    task automatic model_eval();
        int codes[$];
        int mx;
        logic tmo;
        tmo = 1'b0;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
        tmo = pc_if.mem_wait_i && (m_run + 1 == MT);
`endif
        if (pc_if.bus_hold_i)              codes.push_back(1);
        if (m_phase != 0)                  codes.push_back(2);
        if (pc_if.ld_use_i)                codes.push_back(3);
        if (pc_if.div_busy_i)              codes.push_back(4);
        if (pc_if.mem_wait_i && !tmo)      codes.push_back(5);
        mx = 0;
        foreach (codes[i]) if (codes[i] > mx) mx = codes[i];
        e_hold  = 3'(mx);
        e_jf    = pc_if.jump_req_i && (mx < 4);
        e_flush = e_jf ? 3'd4 : 3'd0;
        e_ja    = e_jf ? pc_if.jump_addr_i : 32'd0;
        e_ack   = (m_phase == 2);
        e_err   = tmo;
        if (!rst) begin
            {e_hold, e_flush, e_jf, e_ja, e_err} = '0;
            e_ack = 1'b0;
        end
    endtask

    task automatic model_advance();
        if (!rst) begin
            model_clear();
            return;
        end
        if (pc_if.mem_wait_i) m_run = e_err ? 0 : m_run + 1;
        else                  m_run = 0;
        case (m_phase)
            0: if (pc_if.halt_req_i) begin m_phase = 1; m_left = DC; end
            1: begin
                if (!pc_if.halt_req_i) m_phase = 0;
                else if (e_jf) m_left = DC;
                else if (e_hold == 3'd2) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
            end
            default: if (!pc_if.halt_req_i) m_phase = 0;
        endcase
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, 1'b1, $urandom(), $urandom_range(0, 1) == 1);
            #2;
            n_cmp++;
            if (dut_vec() !== 41'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %h want 0", dut_vec());
            end
            tick();
        end
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        #2;
        model_eval();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_hold_priority();
        set_in(0, 1, 1, 0, 0, 32'd0, 0);
        #2;
        n_cmp++;
        if (pc_if.hold_flag_o !== 3'd4) begin
            n_bad++;
            $display("FAIL hold_div_ld: got %0d want 4", pc_if.hold_flag_o);
        end
        tick();
        set_in(0, 1, 0, 0, 0, 32'd0, 0);
        #2;
        n_cmp++;
        if (pc_if.hold_flag_o !== 3'd3) begin
            n_bad++;
            $display("FAIL hold_ld_only: got %0d want 3", pc_if.hold_flag_o);
        end
        tick();
        for (int i = 0; i < 40; i++) begin
            set_in($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom(), 1'b0);
            #2;
            model_eval();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL hold_random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_jump();
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        tick();
        set_in(0, 0, 0, 0, 1, 32'h0000_0100, 0);
        #2;
        n_cmp++;
        if ({pc_if.jump_flag_o, pc_if.jump_addr_o, pc_if.flush_flag_o} !== {1'b1, 32'h100, 3'd4}) begin
            n_bad++;
            $display("FAIL jump_taken: got %b/%h/%0d want 1/00000100/4",
                     pc_if.jump_flag_o, pc_if.jump_addr_o, pc_if.flush_flag_o);
        end
        tick();
        set_in(0, 0, 0, 1, 1, 32'h0000_0100, 0);
        #2;
        n_cmp++;
        if ({pc_if.hold_flag_o, pc_if.jump_flag_o, pc_if.flush_flag_o, pc_if.jump_addr_o} !==
            {3'd5, 1'b0, 3'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL jump_mem_blocked: got %0d/%b/%0d/%h want 5/0/0/0",
                     pc_if.hold_flag_o, pc_if.jump_flag_o, pc_if.flush_flag_o, pc_if.jump_addr_o);
        end
        tick();
        set_in(1, 1, 0, 0, 1, 32'hCAFE_0004, 0);
        #2;
        model_eval();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL jump_under_id_hold: got %h want %h", dut_vec(), exp_vec());
        end
        tick();
        set_in(0, 0, 1, 0, 1, 32'hCAFE_0008, 0);
        #2;
        n_cmp++;
        if (pc_if.jump_flag_o !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_under_ex_hold: got %b want 0", pc_if.jump_flag_o);
        end
        tick();
    endtask

    task automatic test_halt();
        int exp_lat[3] = '{5, 8, 8};
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        tick();
        for (int s = 0; s < 3; s++) begin
            int c;
            c = 0;
            set_in(0, 0, 0, 0, 0, 32'd0, 1);
            #2;
            n_cmp++;
            if (pc_if.hold_flag_o !== 3'd0) begin
                n_bad++;
                $display("FAIL halt_req_cycle[%0d]: got %0d want 0", s, pc_if.hold_flag_o);
            end
            while (pc_if.halt_ack_o !== 1'b1 && c < 30) begin
                tick();
                c++;
                set_in(0, 0, s == 1 && c >= 2 && c <= 4, 0, s == 2 && c == 3, 32'h0000_2000, 1);
                #2;
                model_eval();
                n_cmp++;
                if (dut_vec() !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL halt_drain[%0d.%0d]: got %h want %h", s, c, dut_vec(), exp_vec());
                end
                if (c == 1) begin
                    n_cmp++;
                    if (pc_if.hold_flag_o !== 3'd2) begin
                        n_bad++;
                        $display("FAIL halt_if_hold[%0d]: got %0d want 2", s, pc_if.hold_flag_o);
                    end
                end
            end
            n_cmp++;
            if (c !== exp_lat[s]) begin
                n_bad++;
                $display("FAIL halt_latency[%0d]: got %0d cycles want %0d", s, c, exp_lat[s]);
            end
            set_in(0, 0, 0, 0, 0, 32'd0, 0);
            #1;
            n_cmp++;
            if (pc_if.halt_ack_o !== 1'b1) begin
                n_bad++;
                $display("FAIL halt_ack_hold[%0d]: got %b want 1", s, pc_if.halt_ack_o);
            end
            tick();
            #2;
            n_cmp++;
            if ({pc_if.halt_ack_o, pc_if.hold_flag_o} !== {1'b0, 3'd0}) begin
                n_bad++;
                $display("FAIL halt_resume[%0d]: got %b/%0d want 0/0", s, pc_if.halt_ack_o, pc_if.hold_flag_o);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 32'd0, 1);
        tick();
        tick();
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        #2;
        n_cmp++;
        if (pc_if.hold_flag_o !== 3'd2) begin
            n_bad++;
            $display("FAIL drain_abort_cycle: got %0d want 2", pc_if.hold_flag_o);
        end
        tick();
        #2;
        n_cmp++;
        if ({pc_if.hold_flag_o, pc_if.halt_ack_o} !== {3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL drain_abort_run: got %0d/%b want 0/0", pc_if.hold_flag_o, pc_if.halt_ack_o);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic want_err;
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        tick();
        for (int k = 1; k <= 20; k++) begin
            set_in(0, 0, 0, 1, 0, 32'd0, 0);
            #2;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
            want_err = (k % MT == 0);
`else
            want_err = 1'b0;
`endif
            n_cmp++;
            if ({pc_if.mem_err_o, pc_if.hold_flag_o} !== {want_err, want_err ? 3'd0 : 3'd5}) begin
                n_bad++;
                $display("FAIL timeout_wait[%0d]: got err=%b hold=%0d want err=%b", k,
                         pc_if.mem_err_o, pc_if.hold_flag_o, want_err);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            set_in(0, 0, 0, 1, 0, 32'd0, 0);
            tick();
        end
        rst = 1'b0;
        model_clear();
        #2;
        n_cmp++;
        if (pc_if.mem_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_in_reset: got %b want 0", pc_if.mem_err_o);
        end
        tick();
        rst = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            #2;
`ifdef PIPE_CTRL_MEM_TIMEOUT_EN
            want_err = (j == MT);
`else
            want_err = 1'b0;
`endif
            n_cmp++;
            if (pc_if.mem_err_o !== want_err) begin
                n_bad++;
                $display("FAIL timeout_after_reset[%0d]: got %b want %b", j, pc_if.mem_err_o, want_err);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        tick();
    endtask

    task automatic test_reset_in_halted();
        int c;
        c = 0;
        set_in(0, 0, 0, 0, 0, 32'd0, 1);
        #2;
        while (pc_if.halt_ack_o !== 1'b1 && c < 30) begin
            tick();
            c++;
            #2;
        end
        n_cmp++;
        if (c !== 5) begin
            n_bad++;
            $display("FAIL halted_entry: got %0d cycles want 5", c);
        end
        rst = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if (dut_vec() !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_in_halted: got %h want 0", dut_vec());
        end
        tick();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        for (int k = 0; k < 2; k++) begin
            #2;
            n_cmp++;
            if ({pc_if.hold_flag_o, pc_if.halt_ack_o} !== {3'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL run_after_reset[%0d]: got %0d/%b want 0/0", k, pc_if.hold_flag_o, pc_if.halt_ack_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic hr;
        hr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) hr = ~hr;
            rst = ($urandom_range(0, 60) != 0);
            if (!rst) model_clear();
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom(), hr);
            #2;
            model_eval();
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'd0, 0);
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_hold_priority();
        test_jump();
        test_halt();
        test_timeout();
        test_reset_in_halted();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
